mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//   MEM-stage consumer of the decode control word (MemRead/MemWrite). Turns a load/store
//   into a req/ack transaction on the data-memory port, stalls the pipeline until the
//   memory responds, then returns load data to the write-back path.
//   Sits between the EX/MEM pipeline register and the data memory.
// PARAMETERS
//   ADDR_W   32  address width (byte address from ALU result)
//   DATA_W   32  data word width
//   TIMEOUT  16  max cycles in REQ before abort (used only with MEM_TIMEOUT_EN)
// PORTS
//   clk          in   1       single clock, all logic on rising edge
//   rst          in   1       synchronous, active-high reset
//   in_valid     in   1       EX/MEM holds a valid instruction
//   mem_read     in   1       MemRead control bit
//   mem_write    in   1       MemWrite control bit
//   addr         in   ADDR_W  ALU result = effective byte address
//   wdata        in   DATA_W  store data (rt)
//   stall        out  1       hold IF..EX/MEM registers this cycle
//   rdata        out  DATA_W  load result to MEM/WB
//   rdata_valid  out  1       1-cycle pulse: rdata holds completed load data
//   align_err    out  1       1-cycle pulse: misaligned access dropped
//   mem_err      out  1       1-cycle pulse: access aborted by timeout
//   dmem_req     out  1       request to data memory
//   dmem_we      out  1       1 = write, 0 = read
//   dmem_addr    out  ADDR_W  registered address
//   dmem_wdata   out  DATA_W  registered write data
//   dmem_rdata   in   DATA_W  read data, valid when dmem_ack=1
//   dmem_ack     in   1       memory completion, sampled only while dmem_req=1
// BEHAVIOUR
//   - States IDLE, REQ, DONE. Reset: state=IDLE; stall, dmem_req, dmem_we, rdata_valid,
//     align_err, mem_err = 0; dmem_addr, dmem_wdata, rdata = 0.
//   - mem_op = in_valid & (mem_read | mem_write). Both bits set -> treated as write.
//   - IDLE: mem_op & addr[1:0]==0 -> latch addr/wdata/we, next=REQ; stall=1 this cycle
//     (combinational from inputs). mem_op & addr[1:0]!=0 -> no request, align_err pulse
//     next cycle, no stall. Non-memory or in_valid=0 -> stay IDLE, stall=0.
//   - REQ: dmem_req=1, address/data/we stable until ack. stall=1. dmem_ack=1 -> next=DONE;
//     on read capture dmem_rdata into rdata. Ack in the first REQ cycle is legal.
//   - DONE: stall=0, rdata_valid=1 for reads only; in_valid ignored (same instruction
//     leaves at this edge); next=IDLE unconditionally.
//   - Latency: zero-wait memory -> stall high 2 cycles (accept + REQ), rdata_valid in 3rd.
//     Each extra wait cycle adds one stall cycle.
//   - dmem_ack outside REQ is ignored. rdata holds last load value until next load.
//   - rst mid-transaction: next edge returns IDLE, dmem_req=0, no rdata_valid/mem_err;
//     a late ack after reset is ignored.
// CONFIGURATION
//   MEM_TIMEOUT_EN defined: counter clears on entry to REQ, increments each REQ cycle
//     without ack; reaching TIMEOUT -> dmem_req drops, next=DONE, mem_err pulses in DONE,
//     rdata_valid=0, rdata unchanged. Ack in the same cycle as expiry wins (normal done).
//   MEM_TIMEOUT_EN undefined: no counter, REQ waits indefinitely, mem_err tied 0.
// TESTING
//   1. lw addr=0x10, ack in first REQ cycle, rdata=0xDEADBEEF -> stall 2 cycles,
//      rdata_valid 1 cycle, rdata=0xDEADBEEF, dmem_we=0.
//   2. sw addr=0x20 wdata=0x1234, ack after 3 waits -> dmem_req 4 cycles with addr/wdata
//      stable, dmem_we=1, stall 5 cycles, rdata_valid never asserted.
//   3. lw addr=0x13 -> dmem_req stays 0, stall 0, align_err pulses once.
//   4. Back-to-back lw 0x4 then sw 0x8 -> two separate REQ phases, one IDLE cycle
//      between, second op not accepted during DONE.
//   5. rst asserted during REQ, ack arrives next cycle -> IDLE, dmem_req=0,
//      no rdata_valid, ack ignored.
//   6. MEM_TIMEOUT_EN, TIMEOUT=4, never ack -> dmem_req high 4 cycles, mem_err pulse,
//      stall released; without macro same stimulus -> stall held indefinitely.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store to req/ack data-memory bridge with pipeline stall; MEM_TIMEOUT_EN adds REQ abort after TIMEOUT cycles
module mem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              align_err,
  output logic              mem_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state;
  logic mem_op, aligned, accept, expire;
  assign mem_op  = in_valid & (mem_read | mem_write);
  assign aligned = addr[1:0] == 2'b00;
  assign accept  = state == IDLE && mem_op && aligned;
  // accept-cycle stall must be combinational so EX/MEM holds the instruction this edge
  assign stall   = accept || state == REQ;
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign expire = !dmem_ack && cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk)
    cnt <= (rst || state != REQ) ? '0 : cnt + 1'b1;
`else
  assign expire = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      align_err   <= 1'b0;
      mem_err     <= 1'b0;
    end else begin
      align_err   <= state == IDLE && mem_op && !aligned;
      rdata_valid <= 1'b0;
      mem_err     <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          state      <= REQ;
          dmem_req   <= 1'b1;
          dmem_we    <= mem_write;
          dmem_addr  <= addr;
          dmem_wdata <= wdata;
        end
        REQ: if (dmem_ack) begin
          state    <= DONE;
          dmem_req <= 1'b0;
          if (!dmem_we) begin
            rdata       <= dmem_rdata;
            rdata_valid <= 1'b1;
          end
        end else if (expire) begin
          state    <= DONE;
          dmem_req <= 1'b0;
          mem_err  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed cycle-by-cycle checks of mem_access_ctrl (TIMEOUT=4)
module tb_mem_access_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0, dmem_ack = 1'b0;
  logic [31:0] addr = '0, wdata = '0, dmem_rdata = '0;
  logic        stall, rdata_valid, align_err, mem_err, dmem_req, dmem_we;
  logic [31:0] rdata, dmem_addr, dmem_wdata;
  int n_tests = 0, n_fail = 0;
  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
    .align_err(align_err), .mem_err(mem_err), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    in_valid = 1'b1; mem_read = rd; mem_write = wr; addr = a; wdata = d;
    #1;
  endtask
  initial begin
    tick; tick;
    rst = 1'b0;
    chk("rst_stall", stall, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rvalid", rdata_valid, 0);
    chk("rst_align", align_err, 0);
    chk("rst_memerr", mem_err, 0);
    // 1: zero-wait load
    issue(1, 0, 32'h10, 32'h0);
    chk("t1_stall_acc", stall, 1);
    chk("t1_req_acc", dmem_req, 0);
    tick; in_valid = 1'b0;
    chk("t1_req", dmem_req, 1);
    chk("t1_we", dmem_we, 0);
    chk("t1_addr", dmem_addr, 32'h10);
    chk("t1_stall_req", stall, 1);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    tick; dmem_ack = 1'b0;
    chk("t1_rvalid", rdata_valid, 1);
    chk("t1_rdata", rdata, 32'hDEADBEEF);
    chk("t1_stall_done", stall, 0);
    chk("t1_req_done", dmem_req, 0);
    tick;
    chk("t1_rvalid_pulse", rdata_valid, 0);
    chk("t1_rdata_hold", rdata, 32'hDEADBEEF);
    // 2: store with 3 wait cycles
    issue(0, 1, 32'h20, 32'h1234);
    chk("t2_stall_acc", stall, 1);
    tick; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_req%0d", i), dmem_req, 1);
      chk($sformatf("t2_addr%0d", i), dmem_addr, 32'h20);
      chk($sformatf("t2_wdata%0d", i), dmem_wdata, 32'h1234);
      chk($sformatf("t2_we%0d", i), dmem_we, 1);
      chk($sformatf("t2_stall%0d", i), stall, 1);
      chk($sformatf("t2_rv%0d", i), rdata_valid, 0);
      dmem_ack = (i == 3); dmem_rdata = 32'hBAD0BAD0;
      tick;
    end
    dmem_ack = 1'b0;
    chk("t2_stall_done", stall, 0);
    chk("t2_req_done", dmem_req, 0);
    chk("t2_rvalid", rdata_valid, 0);
    chk("t2_rdata_keep", rdata, 32'hDEADBEEF);
    tick;
    chk("t2_rvalid_after", rdata_valid, 0);
    // 3: misaligned load
    issue(1, 0, 32'h13, 32'h0);
    chk("t3_stall", stall, 0);
    tick; in_valid = 1'b0;
    chk("t3_align", align_err, 1);
    chk("t3_req", dmem_req, 0);
    tick;
    chk("t3_align_pulse", align_err, 0);
    chk("t3_req2", dmem_req, 0);
    // 4: back-to-back load then store
    issue(1, 0, 32'h4, 32'h0);
    tick;
    chk("t4_req1", dmem_req, 1);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    tick; dmem_ack = 1'b0;
    issue(0, 1, 32'h8, 32'h55);
    chk("t4_done_stall", stall, 0);
    chk("t4_done_rv", rdata_valid, 1);
    chk("t4_done_rdata", rdata, 32'hCAFEF00D);
    tick;
    chk("t4_idle_req", dmem_req, 0);
    chk("t4_idle_stall", stall, 1);
    tick; in_valid = 1'b0;
    chk("t4_req2", dmem_req, 1);
    chk("t4_addr2", dmem_addr, 32'h8);
    chk("t4_we2", dmem_we, 1);
    chk("t4_wdata2", dmem_wdata, 32'h55);
    dmem_ack = 1'b1;
    tick; dmem_ack = 1'b0;
    chk("t4_rv2", rdata_valid, 0);
    chk("t4_rdata_keep", rdata, 32'hCAFEF00D);
    tick;
    // 5: reset during REQ, late ack
    issue(1, 0, 32'h40, 32'h0);
    tick; in_valid = 1'b0;
    chk("t5_req", dmem_req, 1);
    rst = 1'b1;
    tick; rst = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'h11111111;
    #1;
    chk("t5_req_rst", dmem_req, 0);
    chk("t5_stall_rst", stall, 0);
    chk("t5_rdata_rst", rdata, 0);
    tick; dmem_ack = 1'b0;
    chk("t5_rvalid", rdata_valid, 0);
    chk("t5_req_late", dmem_req, 0);
    chk("t5_rdata_late", rdata, 0);
    chk("t5_memerr", mem_err, 0);
    // 6: never acknowledged
    issue(1, 0, 32'h50, 32'h0);
    tick; in_valid = 1'b0;
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t6_req%0d", i), dmem_req, 1);
      chk($sformatf("t6_err%0d", i), mem_err, 0);
      tick;
    end
    chk("t6_memerr", mem_err, 1);
    chk("t6_stall", stall, 0);
    chk("t6_req_drop", dmem_req, 0);
    chk("t6_rvalid", rdata_valid, 0);
    chk("t6_rdata", rdata, 0);
    tick;
    chk("t6_memerr_pulse", mem_err, 0);
`else
    for (int i = 0; i < 30; i++) tick;
    chk("t6_stall_held", stall, 1);
    chk("t6_req_held", dmem_req, 1);
    chk("t6_memerr", mem_err, 0);
    rst = 1'b1;
    tick; rst = 1'b0;
    chk("t6_rst_req", dmem_req, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
